// File: rtl/shift_sub_divider.sv
// shift_sub_divider: sequential restoring shift-subtract divider, 2N-bit dividend / N-bit divisor
// Ports: CK clock; RST sync active-high reset; START request; DVD dividend (2N);
//        DVS divisor (N); READY idle/done and able to accept; QUO quotient (N);
//        REM remainder (N); OVF last operation overflowed (quotient >= 2^N or DVS == 0).
// Option: define DIV_RESTART_EN to let START during BUSY abort and restart with new operands.
module shift_sub_divider #(
    parameter int N = 4
) (
    input  logic           CK,
    input  logic           RST,
    input  logic           START,
    input  logic [2*N-1:0] DVD,
    input  logic [N-1:0]   DVS,
    output logic           READY,
    output logic [N-1:0]   QUO,
    output logic [N-1:0]   REM,
    output logic           OVF
);
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t        state;
    logic [N-1:0]  pr, sl, dvs_r;
    logic [CW-1:0] cnt;
    logic [N:0]    t;
    logic          qbit, take, last;
    logic [N-1:0]  pr_n, sl_n;
    // PR < DVS holds before each step, so the sign bit of t is a valid borrow
    always_comb begin
        t    = {pr, sl[N-1]} - {1'b0, dvs_r};
        qbit = ~t[N];
        pr_n = qbit ? t[N-1:0] : {pr[N-2:0], sl[N-1]};
        sl_n = {sl[N-2:0], qbit};
        last = cnt == CW'(N - 1);
`ifdef DIV_RESTART_EN
        take = START;
`else
        take = START && state != BUSY;
`endif
    end
    assign READY = state != BUSY;
    always_ff @(posedge CK) begin
        if (RST) begin
            state <= IDLE;
            pr    <= '0;
            sl    <= '0;
            dvs_r <= '0;
            cnt   <= '0;
            QUO   <= '0;
            REM   <= '0;
            OVF   <= 1'b0;
        end else if (take) begin
            // high half >= divisor means the quotient cannot fit in N bits (covers DVS == 0)
            if (DVD[2*N-1:N] >= DVS) begin
                state <= DONE;
                QUO   <= '1;
                REM   <= '0;
                OVF   <= 1'b1;
            end else begin
                state <= BUSY;
                pr    <= DVD[2*N-1:N];
                sl    <= DVD[N-1:0];
                dvs_r <= DVS;
                cnt   <= '0;
            end
        end else if (state == BUSY) begin
            pr  <= pr_n;
            sl  <= sl_n;
            cnt <= last ? '0 : cnt + CW'(1);
            if (last) begin
                state <= DONE;
                QUO   <= sl_n;
                REM   <= pr_n;
                OVF   <= 1'b0;
            end
        end
    end
endmodule

// File: doc/shift_sub_divider.md
# shift_sub_divider

Sequential restoring shift-subtract divider, the inverse of the team's 4x4 shift-add multiplier: takes a 2N-bit dividend (a product-width value) and an N-bit divisor and returns an N-bit quotient and N-bit remainder. It uses the same START/READY control style and a cycle counter like the multiplier. It sits beside the multiplier in the arithmetic test-circuit set, and its quotient/remainder recover the multiplier operands from its product.

## Interface
- N, default 4, operand width; dividend is 2N bits; N must be 2..8
- CK  input  1  clock, all state changes on rising edge
- RST  input  1  reset, synchronous, active-high
- START  input  1  request; sampled each rising edge
- DVD  input  2N  dividend, captured on accepted START
- DVS  input  N  divisor, captured on accepted START
- READY  output  1  high when idle/done and able to accept START
- QUO  output  N  quotient of last completed operation
- REM  output  N  remainder of last completed operation
- OVF  output  1  last operation overflowed (quotient >= 2^N or DVS == 0)

## Operation
- States: IDLE, BUSY, DONE. DONE behaves like IDLE for START acceptance; DONE exists only to mark held results.
- Reset (RST=1 at an edge, any state, overrides START): state IDLE, READY=1, QUO=0, REM=0, OVF=0, counter 0, working registers 0.
- Accept: START=1 at an edge with READY=1 captures DVD/DVS.
  - Overflow check at capture: DVD[2N-1:N] >= DVS (this includes DVS==0) -> next state DONE, QUO=all ones, REM=0, OVF=1.
  - Otherwise -> BUSY; partial remainder PR=DVD[2N-1:N], shift register SL=DVD[N-1:0], counter=0, OVF cleared at completion.
- BUSY iteration (one per edge): T={PR,SL[N-1]} - {1'b0,DVS} in N+1 bits; if T>=0, PR=T[N-1:0] and qbit=1, else PR={PR[N-2:0],SL[N-1]} and qbit=0; SL={SL[N-2:0],qbit}; counter+1.
- The edge performing iteration N (counter N-1 -> wraps to 0) loads QUO=SL', REM=PR', OVF=0 and moves to DONE.
- QUO/REM/OVF are output registers. They change only on reset, at completion, or at overflow capture. They hold the previous result throughout BUSY.
- START while BUSY: see Configuration. START at the same edge as completion is not accepted, because READY is still 0 in that cycle.
- Invariant: PR < DVS before every iteration, so PR never needs more than N bits.

## Timing
- Accept edge E0: READY falls after E0.
- Normal case: iterations at edges E1..EN. QUO/REM valid and READY=1 after EN. READY is low for exactly N cycles.
- Overflow case: result and READY=1 immediately after E0. READY is never low.
- Back-to-back: START may be held high. The next operation is accepted at the first edge with READY=1, which gives a throughput of one result per N+1 cycles.
- No combinational path from inputs to outputs.

## Configuration
- DIV_RESTART_EN defined: START=1 at an edge while BUSY aborts the current operation and accepts new operands exactly as from IDLE, including the overflow check. QUO/REM/OVF keep their previous values. READY stays 0 unless the new operation overflows.
- DIV_RESTART_EN undefined: START while BUSY is ignored. The operation completes normally, and a still-high START is accepted on the first edge after completion.

## Test plan
- N=4, DVD=100, DVS=7, START one cycle -> READY low 4 cycles, then QUO=14, REM=2, OVF=0; reset values QUO=0, REM=0, READY=1 checked before start.
- DVD=239, DVS=15 -> QUO=15, REM=14. DVD=0, DVS=1 -> QUO=0, REM=0. DVD=119, DVS=8 -> QUO=14, REM=7.
- DVD=128, DVS=8 -> OVF=1, QUO=15, REM=0, READY high after 1 edge. DVD=5, DVS=0 -> same OVF response.
- Exhaustive sweep: all DVD with DVD[7:4] < DVS, DVS=1..15 -> QUO*DVS+REM==DVD and REM<DVS. Covers multiplier round-trip: DVD=A*B, DVS=B -> QUO=A, REM=0.
- RST=1 at the 2nd BUSY edge of 100/7 with START=1 -> IDLE, READY=1, outputs 0, START ignored that edge; the next op 45/6 gives QUO=7, REM=3.
- START of 50/3 at the 2nd BUSY edge of 100/7 -> with DIV_RESTART_EN: QUO=16 is overflow? No: 50 has high nibble 3 >= 3, so OVF=1, QUO=15, REM=0 one edge later. Without DIV_RESTART_EN: QUO=14, REM=2 first.
